reaction_timer_ctrl: RTL and testbench

- Parametrised reaction-timer controller: start, random delay, LED stimulus, BCD millisecond count, stop capture.
- Adds over the previous generation:
  - configurable digit count and tick rate
  - internal LFSR delay generator
  - cheat detection and timeout states
  - best-time register and round counter
- Drives the display mux via a flat BCD bus plus a per-digit blank mask.
- start/stop/clear arrive already debounced as single-cycle pulses.

---
 rtl/reaction_timer_ctrl_if.sv | 32 +++
 rtl/reaction_timer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer_ctrl_if
//  Function : Player-button and display/status bundle for the reaction timer.
//             master = button/display side, slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface reaction_timer_ctrl_if #(
   parameter int N_DIGITS = 4
) ();
   logic                    start;
   logic                    stop;
   logic                    clear;
   logic [4*N_DIGITS-1:0]   digits;
   logic [N_DIGITS-1:0]     blank;
   logic                    led;
   logic [4*N_DIGITS-1:0]   best;
   logic                    best_valid;
   logic [7:0]              rounds;
   logic [2:0]              state;

   modport master (
      output start, stop, clear,
      input  digits, blank, led, best, best_valid, rounds, state
   );

   modport slave (
      input  start, stop, clear,
      output digits, blank, led, best, best_valid, rounds, state
   );
endinterface
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer_ctrl
//  Function : Reaction-timer controller. Random LFSR delay, LED stimulus,
//             BCD millisecond count, cheat/timeout detection, best time and
//             round counter. All outputs registered.
//  Revision : 1.0  initial release
// ============================================================================
module reaction_timer_ctrl #(
   parameter int         TICK_DIV     = 100000,
   parameter int         N_DIGITS     = 4,
   parameter int         LFSR_W       = 16,
   parameter int         DLY_BITS     = 11,
   parameter int         MIN_DELAY_MS = 1000,
   parameter logic [3:0] ERR_CODE     = 4'hE
) (
   input  logic                 clk,
   input  logic                 rst,
   reaction_timer_ctrl_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);
   // Wide enough for the largest possible delay MIN_DELAY_MS + 2^DLY_BITS - 1
   localparam int DW = $clog2(MIN_DELAY_MS + (1 << DLY_BITS));
   localparam int BW = 4 * N_DIGITS;
   localparam logic [BW-1:0] NINES = {N_DIGITS{4'h9}};
   localparam logic [BW-1:0] ERRS  = {N_DIGITS{ERR_CODE}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_TIMING = 3'd2,
      S_DONE   = 3'd3,
      S_CHEAT  = 3'd4,
      S_TMO    = 3'd5
   } state_t;

   state_t             cur;
   logic [LFSR_W-1:0]  lfsr;
   logic               fb;
   logic [PW-1:0]      presc;
   logic               tick;
   logic [DW-1:0]      dly_cnt;
   logic [DW-1:0]      dly_init;
   logic [BW-1:0]      bcd;
   logic [BW-1:0]      bcd_inc;
   logic               carry;
   logic               start_ok;

   // Maximal-length feedback taps for each supported width
   generate
      if (LFSR_W == 8) begin : g_taps_8
         assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      end else if (LFSR_W == 24) begin : g_taps_24
         assign fb = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
      end else begin : g_taps_16
         assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      end
   endgenerate

   assign tick      = (presc == PW'(TICK_DIV - 1));
   assign dly_init  = DW'(MIN_DELAY_MS) + DW'(lfsr[DLY_BITS-1:0]);
   // A new round may begin from any state that is not an active round
   assign start_ok  = bus.start && (cur != S_WAIT) && (cur != S_TIMING);
   assign bus.state = cur;

   // Free-running Fibonacci LFSR; soft clear leaves it alone so rounds stay random
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr <= LFSR_W'(1);
      end else begin
         lfsr <= {lfsr[LFSR_W-2:0], fb};
      end
   end

   // Decimal increment with carry ripple from digit 0 upward
   always_comb begin
      carry   = 1'b1;
      bcd_inc = bcd;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (carry) begin
            if (bcd[4*i +: 4] == 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   // Round state machine with registered display, LED and score outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur            <= S_IDLE;
         presc          <= '0;
         dly_cnt        <= '0;
         bcd            <= '0;
         bus.led        <= 1'b0;
         bus.digits     <= '0;
         bus.blank      <= '1;
         bus.best       <= NINES;
         bus.best_valid <= 1'b0;
         bus.rounds     <= 8'd0;
      end else if (bus.clear) begin
         cur            <= S_IDLE;
         presc          <= '0;
         dly_cnt        <= '0;
         bcd            <= '0;
         bus.led        <= 1'b0;
         bus.digits     <= NINES;
         bus.blank      <= '1;
         bus.best       <= NINES;
         bus.best_valid <= 1'b0;
         bus.rounds     <= 8'd0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (start_ok) begin
            cur        <= S_WAIT;
            dly_cnt    <= dly_init;
            presc      <= '0;
            bus.led    <= 1'b0;
            bus.digits <= '0;
            bus.blank  <= '1;
         end else begin
            case (cur)
               S_WAIT: begin
                  if (bus.stop) begin
                     cur        <= S_CHEAT;
                     bus.digits <= ERRS;
                     bus.blank  <= '0;
                  end else if (tick) begin
                     // Last tick of the delay: light the LED and start counting
                     if (dly_cnt <= DW'(1)) begin
                        cur        <= S_TIMING;
                        presc      <= '0;
                        bcd        <= '0;
                        bus.led    <= 1'b1;
                        bus.digits <= '0;
                        bus.blank  <= '0;
                     end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                     end
                  end
               end
               S_TIMING: begin
                  if (bus.stop) begin
                     // Freeze the count as it stood before any same-cycle tick
                     cur        <= S_DONE;
                     bus.led    <= 1'b0;
                     bus.digits <= bcd;
                     if (bus.rounds != 8'hFF) begin
                        bus.rounds <= bus.rounds + 8'd1;
                     end
                     // 4-bit digit fields make an unsigned compare equal to an MSB-first digit compare
                     if (!bus.best_valid || (bcd < bus.best)) begin
                        bus.best       <= bcd;
                        bus.best_valid <= 1'b1;
                     end
                  end else if (tick) begin
                     if (bcd == NINES) begin
                        cur        <= S_TMO;
                        bus.led    <= 1'b0;
                        bus.digits <= NINES;
                     end else begin
                        bcd        <= bcd_inc;
                        bus.digits <= bcd_inc;
                     end
                  end
               end
               default: begin
                  // IDLE, DONE, CHEAT and TMO hold their outputs until start or clear
               end
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reaction_timer_ctrl
//  Function : Self-checking bench for reaction_timer_ctrl with a behavioural
//             model of delay, reaction value, best time and round count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reaction_timer_ctrl;
   localparam int         TICK_DIV     = 4;
   localparam int         N_DIGITS     = 3;
   localparam int         LFSR_W       = 16;
   localparam int         DLY_BITS     = 3;
   localparam int         MIN_DELAY_MS = 2;
   localparam logic [3:0] ERR_CODE     = 4'hE;
   localparam int         BW           = 4 * N_DIGITS;
   localparam int         MAXV         = 10 ** N_DIGITS - 1;
   // x^16 + x^14 + x^13 + x^11 + 1 expressed as a tap mask
   localparam logic [15:0] TAPS        = 16'hB400;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic [LFSR_W-1:0] lfsr_m;
   int   best_m   = -1;
   int   rounds_m = 0;

   reaction_timer_ctrl_if #(.N_DIGITS(N_DIGITS)) bus ();

   reaction_timer_ctrl #(
      .TICK_DIV     (TICK_DIV),
      .N_DIGITS     (N_DIGITS),
      .LFSR_W       (LFSR_W),
      .DLY_BITS     (DLY_BITS),
      .MIN_DELAY_MS (MIN_DELAY_MS),
      .ERR_CODE     (ERR_CODE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference pseudo-random sequence from the feedback polynomial
   always @(posedge clk or negedge rst) begin
      if (!rst) lfsr_m <= 16'd1;
      else      lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & TAPS)};
   end

   function automatic logic [BW-1:0] to_bcd(input int v);
      logic [BW-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < N_DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reaction value for a stop sampled 'off' edges after the LED edge
   function automatic int react(input int off);
      int v;
      v = (off - 1) / TICK_DIV;
      return (v > MAXV) ? MAXV : v;
   endfunction

   function automatic logic [BW-1:0] best_exp();
      return (best_m < 0) ? to_bcd(MAXV) : to_bcd(best_m);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_round(output int s, output int d);
      d = MIN_DELAY_MS + int'(lfsr_m[DLY_BITS-1:0]);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      s = cyc;
      chk("wait_state", 32'(bus.state), 32'd1);
      chk("wait_blank", 32'(bus.blank), 32'h7);
   endtask

   task automatic wait_timing(input int s, input int d, output int t0);
      int n;
      n = 0;
      while (bus.led !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      chk("wait_len", 32'(t0 - s), 32'(d * TICK_DIV));
      chk("timing_state", 32'(bus.state), 32'd2);
      chk("timing_blank", 32'(bus.blank), 32'd0);
   endtask

   task automatic stop_at(input int target);
      while (cyc < target - 1) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
   endtask

   task automatic play(input int off);
      int s, d, t0, v;
      start_round(s, d);
      wait_timing(s, d, t0);
      stop_at(t0 + off);
      v = react(off);
      if (rounds_m < 255) rounds_m++;
      if (best_m < 0 || v < best_m) best_m = v;
      chk("done_state", 32'(bus.state), 32'd3);
      chk("done_led", 32'(bus.led), 32'd0);
      chk("done_digits", 32'(bus.digits), 32'(to_bcd(v)));
      chk("done_best", 32'(bus.best), 32'(best_exp()));
      chk("done_best_valid", 32'(bus.best_valid), 32'd1);
      chk("done_rounds", 32'(bus.rounds), 32'(rounds_m));
   endtask

   task automatic cheat(input bit coincide);
      int s, d, k;
      start_round(s, d);
      k = coincide ? d * TICK_DIV : int'($urandom_range(1, d * TICK_DIV - 1));
      stop_at(s + k);
      chk("cheat_state", 32'(bus.state), 32'd4);
      chk("cheat_digits", 32'(bus.digits), 32'({N_DIGITS{ERR_CODE}}));
      chk("cheat_led", 32'(bus.led), 32'd0);
      chk("cheat_rounds", 32'(bus.rounds), 32'(rounds_m));
      chk("cheat_best", 32'(bus.best), 32'(best_exp()));
   endtask

   initial begin
      int s, d, t0, n;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_led", 32'(bus.led), 32'd0);
      chk("rst_digits", 32'(bus.digits), 32'd0);
      chk("rst_blank", 32'(bus.blank), 32'h7);
      chk("rst_best", 32'(bus.best), 32'h999);
      chk("rst_best_valid", 32'(bus.best_valid), 32'd0);
      chk("rst_rounds", 32'(bus.rounds), 32'd0);
      rst = 1'b1;

      // First round starts when the low LFSR bits read 5 (delay 7 ms)
      n = 0;
      while (lfsr_m[DLY_BITS-1:0] != 3'd5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      play(37 * TICK_DIV + int'($urandom_range(1, TICK_DIV)));
      play(52 * TICK_DIV + int'($urandom_range(1, TICK_DIV)));
      play(19 * TICK_DIV + int'($urandom_range(1, TICK_DIV)));

      // Soft clear from DONE wipes score state
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      best_m   = -1;
      rounds_m = 0;
      chk("clr_state", 32'(bus.state), 32'd0);
      chk("clr_blank", 32'(bus.blank), 32'h7);
      chk("clr_best_valid", 32'(bus.best_valid), 32'd0);
      chk("clr_rounds", 32'(bus.rounds), 32'd0);
      chk("clr_best", 32'(bus.best), 32'h999);

      for (int i = 0; i < 4; i++) play(int'($urandom_range(1, 150 * TICK_DIV)));
      play(1);
      cheat(1'b0);
      cheat(1'b1);
      play(int'($urandom_range(1, 60 * TICK_DIV)));

      // Asynchronous reset in the middle of a timed interval
      start_round(s, d);
      wait_timing(s, d, t0);
      repeat (int'($urandom_range(5, 40))) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      best_m   = -1;
      rounds_m = 0;
      chk("arst_led", 32'(bus.led), 32'd0);
      chk("arst_state", 32'(bus.state), 32'd0);
      chk("arst_blank", 32'(bus.blank), 32'h7);
      chk("arst_best", 32'(bus.best), 32'h999);
      chk("arst_rounds", 32'(bus.rounds), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Timeout: no stop, count runs to all nines then gives up
      start_round(s, d);
      wait_timing(s, d, t0);
      while (cyc < t0 + (MAXV - 1) * TICK_DIV) @(negedge clk);
      chk("tmo_998", 32'(bus.digits), 32'(to_bcd(MAXV - 1)));
      while (cyc < t0 + MAXV * TICK_DIV) @(negedge clk);
      chk("tmo_999", 32'(bus.digits), 32'(to_bcd(MAXV)));
      chk("tmo_999_state", 32'(bus.state), 32'd2);
      while (cyc < t0 + (MAXV + 1) * TICK_DIV) @(negedge clk);
      chk("tmo_state", 32'(bus.state), 32'd5);
      chk("tmo_digits", 32'(bus.digits), 32'(to_bcd(MAXV)));
      chk("tmo_led", 32'(bus.led), 32'd0);
      chk("tmo_rounds", 32'(bus.rounds), 32'(rounds_m));
      chk("tmo_best_valid", 32'(bus.best_valid), 32'd0);

      // Stop on the very tick that would time out
      play((MAXV + 1) * TICK_DIV);

      // start and stop together from DONE begin a new round
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("startstop_state", 32'(bus.state), 32'd1);

      // clear with start in the same cycle lands in IDLE
      bus.clear = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.start = 1'b0;
      chk("clrstart_state", 32'(bus.state), 32'd0);
      chk("clrstart_rounds", 32'(bus.rounds), 32'd0);

      // stop in IDLE is ignored
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      @(negedge clk);
      chk("idle_stop_state", 32'(bus.state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
